// File: rtl/mac_pkg.sv
// mac_pkg: shared tag bundle and saturation bounds for the vector MAC
package mac_pkg;
  typedef struct packed {
    logic valid;
    logic first;
    logic last;
  } tag_t;
  function automatic logic signed [63:0] sat_max(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction
  function automatic logic signed [63:0] sat_min(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction
endpackage

// File: rtl/mac_mult_pipe.sv
// mac_mult_pipe: full-precision signed multiplier over STAGES registers with aligned tags
module mac_mult_pipe import mac_pkg::*; #(
  parameter int A_W = 10,
  parameter int B_W = 10,
  parameter int STAGES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [A_W-1:0]    a,
  input  logic signed [B_W-1:0]    b,
  input  tag_t                     tag_in,
  output logic signed [A_W+B_W-1:0] p,
  output tag_t                     tag_out
);
  localparam int P_W = A_W + B_W;
  logic signed [P_W-1:0] prod [STAGES];
  tag_t tag [STAGES];
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      for (int i = 0; i < STAGES; i++) begin
        prod[i] <= '0;
        tag[i] <= '0;
      end
    end else begin
      prod[0] <= P_W'(a) * P_W'(b);
      tag[0] <= tag_in;
      for (int i = 1; i < STAGES; i++) begin
        prod[i] <= prod[i-1];
        tag[i] <= tag[i-1];
      end
    end
  assign p = prod[STAGES-1];
  assign tag_out = tag[STAGES-1];
endmodule

// File: rtl/mac_vec_pipe.sv
// mac_vec_pipe: pipelined signed saturating dot-product engine with one result per vector
module mac_vec_pipe import mac_pkg::*; #(
  parameter int A_W = 10,
  parameter int B_W = 10,
  parameter int ACC_W = 20,
  parameter int MULT_STAGES = 2,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic signed [A_W-1:0]   a,
  input  logic signed [B_W-1:0]   b,
  input  logic [CNT_W-1:0]        vec_len,
  output logic signed [ACC_W-1:0] f,
  output logic                    valid_out,
  output logic                    sat
);
  localparam int P_W = A_W + B_W;
  localparam logic signed [63:0] MAX64 = sat_max(ACC_W);
  localparam logic signed [63:0] MIN64 = sat_min(ACC_W);
  localparam logic signed [ACC_W-1:0] ACC_MAX = MAX64[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0] ACC_MIN = MIN64[ACC_W-1:0];
  if (ACC_W < P_W) begin : g_bad_acc_w
    $error("ACC_W must be at least A_W+B_W");
  end
  if (MULT_STAGES < 1) begin : g_bad_stages
    $error("MULT_STAGES must be at least 1");
  end
  logic [CNT_W-1:0] cnt, len, len_cur;
  logic first_in, last_in;
  logic signed [A_W-1:0] in_a;
  logic signed [B_W-1:0] in_b;
  tag_t in_tag, tag_m, tag_r;
  logic signed [P_W-1:0] p_m;
  logic signed [ACC_W-1:0] p_r, acc, base, sum, res;
  logic acc_sat, ovf, unf, sat_n;
  assign first_in = cnt == '0;
  assign len_cur = first_in ? (vec_len == '0 ? CNT_W'(1) : vec_len) : len;
  assign last_in = cnt + CNT_W'(1) == len_cur;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt <= '0;
      len <= '0;
      in_a <= '0;
      in_b <= '0;
      in_tag <= '0;
    end else begin
      in_a <= a;
      in_b <= b;
      in_tag <= '{valid: valid_in, first: first_in, last: last_in};
      if (valid_in) begin
        len <= len_cur;
        cnt <= last_in ? '0 : cnt + CNT_W'(1);
      end
    end
  mac_mult_pipe #(.A_W(A_W), .B_W(B_W), .STAGES(MULT_STAGES)) u_mult (
    .clk(clk), .reset(reset), .a(in_a), .b(in_b), .tag_in(in_tag), .p(p_m), .tag_out(tag_m)
  );
  // Overflow is only possible when both addends share a sign and the sum flips it
  assign base = tag_r.first ? '0 : acc;
  assign sum = base + p_r;
  assign ovf = !base[ACC_W-1] && !p_r[ACC_W-1] && sum[ACC_W-1];
  assign unf = base[ACC_W-1] && p_r[ACC_W-1] && !sum[ACC_W-1];
  assign res = ovf ? ACC_MAX : unf ? ACC_MIN : sum;
  assign sat_n = (!tag_r.first && acc_sat) || ovf || unf;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      p_r <= '0;
      tag_r <= '0;
      acc <= '0;
      acc_sat <= 1'b0;
      f <= '0;
      sat <= 1'b0;
      valid_out <= 1'b0;
    end else begin
      p_r <= ACC_W'(p_m);
      tag_r <= tag_m;
      valid_out <= tag_r.valid && tag_r.last;
      if (tag_r.valid && tag_r.last) begin
        f <= res;
        sat <= sat_n;
        acc <= '0;
        acc_sat <= 1'b0;
      end else if (tag_r.valid) begin
        acc <= res;
        acc_sat <= sat_n;
      end
    end
endmodule

// File: tb/tb_mac_vec_pipe.sv
// tb_mac_vec_pipe: directed vectors checked against a dot-product model and hand-computed values
module tb_mac_vec_pipe;
  logic clk = 0;
  logic reset = 1;
  logic valid_in, valid_in2;
  logic signed [9:0] a, b;
  logic signed [15:0] a2, b2;
  logic [7:0] vec_len;
  logic signed [19:0] f0, f1;
  logic signed [31:0] f2;
  logic vo0, vo1, vo2, sat0, sat1, sat2;
  int n_checks = 0, n_fail = 0;

  always #5 clk = ~clk;

  mac_vec_pipe u0 (.clk(clk), .reset(reset), .valid_in(valid_in), .a(a), .b(b),
    .vec_len(vec_len), .f(f0), .valid_out(vo0), .sat(sat0));
  mac_vec_pipe #(.MULT_STAGES(3)) u1 (.clk(clk), .reset(reset), .valid_in(valid_in), .a(a), .b(b),
    .vec_len(vec_len), .f(f1), .valid_out(vo1), .sat(sat1));
  mac_vec_pipe #(.A_W(16), .B_W(16), .ACC_W(32)) u2 (.clk(clk), .reset(reset), .valid_in(valid_in2),
    .a(a2), .b(b2), .vec_len(vec_len), .f(f2), .valid_out(vo2), .sat(sat2));

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Dot-product model for u0: clamps the running sum to the 20-bit range after every product
  typedef struct {int due; longint f; logic s;} res_t;
  res_t q[$];
  localparam longint MAXV = 524287;
  localparam longint MINV = -524288;
  int cyc = 0, mcnt = 0, mlen = 1;
  longint macc = 0, exp_f = 0;
  logic msat = 0, exp_sat = 0, exp_vo;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      mcnt = 0;
      exp_f = 0;
      exp_sat = 0;
    end else begin
      cyc++;
      if (valid_in) begin
        longint s;
        if (mcnt == 0) begin
          mlen = (vec_len == 0) ? 1 : int'(vec_len);
          macc = 0;
          msat = 0;
        end
        s = macc + longint'(a) * longint'(b);
        if (s > MAXV) begin s = MAXV; msat = 1; end
        if (s < MINV) begin s = MINV; msat = 1; end
        mcnt++;
        if (mcnt == mlen) begin
          q.push_back('{cyc + 4, s, msat});
          mcnt = 0;
        end else macc = s;
      end
    end
  end

  always @(negedge clk)
    if (reset) begin
      exp_vo = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
        exp_f = q[0].f;
        exp_sat = q[0].s;
        exp_vo = 1;
        void'(q.pop_front());
      end
      chk("model_valid_out", vo0, exp_vo);
      chk("model_f", f0, exp_f);
      chk("model_sat", sat0, exp_sat);
    end

  task automatic send(input logic signed [9:0] x, input logic signed [9:0] y, input int len);
    valid_in = 1;
    a = x;
    b = y;
    vec_len = 8'(len);
    @(negedge clk);
  endtask

  task automatic idle();
    valid_in = 0;
    @(negedge clk);
  endtask

  task automatic wait_pulse(output int n);
    valid_in = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vo0 && n < 20);
  endtask

  initial begin
    int n;
    valid_in = 0; valid_in2 = 0; a = 0; b = 0; a2 = 0; b2 = 0; vec_len = 0;
    #1 reset = 0;
    repeat (3) @(negedge clk);
    chk("reset_f", f0, 0);
    chk("reset_valid_out", vo0, 0);
    chk("reset_sat", sat0, 0);
    #2 reset = 1;

    send(2, 3, 3); send(4, -5, 3); send(-1, -7, 3);
    wait_pulse(n);
    chk("basic_latency", n, 4);
    chk("basic_f", f0, -7);
    chk("basic_sat", sat0, 0);
    chk("stages3_not_yet", vo1, 0);
    @(negedge clk);
    chk("basic_pulse_width", vo0, 0);
    chk("stages3_latency", vo1, 1);
    chk("stages3_f", f1, -7);

    send(-512, -512, 3); send(-512, -512, 3); send(-512, -512, 3);
    wait_pulse(n);
    chk("overflow_f", f0, 524287);
    chk("overflow_sat", sat0, 1);

    send(1, 1, 4); send(1, 1, 4);
    #2 reset = 0;
    #1;
    chk("async_reset_f", f0, 0);
    chk("async_reset_valid_out", vo0, 0);
    chk("async_reset_sat", sat0, 0);
    @(negedge clk);
    #2 reset = 1;
    send(5, 5, 2); send(1, 1, 2);
    wait_pulse(n);
    chk("after_reset_f", f0, 26);
    chk("after_reset_latency", n, 4);

    send(-512, 511, 3); send(-512, 511, 3); send(-512, 511, 3);
    wait_pulse(n);
    chk("underflow_f", f0, -524288);
    chk("underflow_sat", sat0, 1);
    send(1, 1, 1);
    wait_pulse(n);
    chk("len1_f", f0, 1);
    chk("len1_sat_clear", sat0, 0);

    send(1, 1, 2); send(1, 1, 2); send(3, 3, 2); send(-2, 2, 2);
    wait_pulse(n);
    chk("b2b_first_f", f0, 2);
    wait_pulse(n);
    chk("b2b_spacing", n, 2);
    chk("b2b_second_f", f0, 5);

    send(1, 1, 2); send(1, 1, 2); send(3, 3, 2); idle(); send(-2, 2, 2);
    wait_pulse(n);
    chk("gap_first_f", f0, 2);
    wait_pulse(n);
    chk("gap_spacing", n, 3);
    chk("gap_second_f", f0, 5);

    send(1, 2, 3); send(1, 2, 0); send(1, 2, 7);
    wait_pulse(n);
    chk("len_change_ignored_f", f0, 6);

    send(7, 2, 0);
    wait_pulse(n);
    chk("len0_f", f0, 14);
    chk("len0_latency", n, 4);

    valid_in = 0;
    vec_len = 2;
    valid_in2 = 1; a2 = -32768; b2 = -32768;
    repeat (2) @(negedge clk);
    valid_in2 = 0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!vo2 && n < 20);
    chk("wide_latency", n, 4);
    chk("wide_f", f2, 2147483647);
    chk("wide_sat", sat2, 1);

    repeat (6) @(negedge clk);
    chk("model_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
